// File: rtl/regfile_bypass.sv
// Decode-stage integer register file: two bypassed read ports, one debug port.
// A sequential clear sweep zeroes every entry after reset; busy tracks it.
module regfile_bypass #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              write,
    input  logic [ADDR_W-1:0] write_address,
    input  logic [DATA_W-1:0] write_data_in,
    input  logic [ADDR_W-1:0] read_address_1,
    input  logic [ADDR_W-1:0] read_address_2,
    input  logic [ADDR_W-1:0] read_address_debug,
    output logic [DATA_W-1:0] data_out_1,
    output logic [DATA_W-1:0] data_out_2,
    output logic [DATA_W-1:0] data_out_debug,
    output logic              busy
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] idx_nxt;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              wr_ok;
    logic              byp_1;
    logic              byp_2;
    logic [DATA_W-1:0] rd_1;
    logic [DATA_W-1:0] rd_2;
    logic [DATA_W-1:0] rd_dbg;

    function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    // Sweep state and clear index; reset restarts the sweep at entry 0
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= CLEAR;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    // Advance the sweep one entry per cycle until the last entry is cleared
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        case (state)
            CLEAR: begin
                idx_nxt = idx + ADDR_W'(1);
                if (idx == LAST) begin
                    state_nxt = RUN;
                end
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    // Busy simply reflects the sweep state
    always_comb begin
        busy = (state == CLEAR);
    end

    // Write qualification, bypass detection and zero-register masking
    always_comb begin
        wr_ok  = write && !is_zero_reg(write_address);
        byp_1  = (BYPASS != 0) && wr_ok
                 && (write_address == read_address_1);
        byp_2  = (BYPASS != 0) && wr_ok
                 && (write_address == read_address_2);
        rd_1   = is_zero_reg(read_address_1)
                 ? '0 : mem[read_address_1];
        rd_2   = is_zero_reg(read_address_2)
                 ? '0 : mem[read_address_2];
        rd_dbg = is_zero_reg(read_address_debug)
                 ? '0 : mem[read_address_debug];
    end

    // Storage: the sweep owns the array until it finishes
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (state == CLEAR) begin
                mem[idx] <= '0;
            end else if (wr_ok) begin
                mem[write_address] <= write_data_in;
            end
        end
    end

    // Registered reads; debug port always sees the stored value
    always_ff @(posedge clock) begin
        if (reset || state == CLEAR) begin
            data_out_1     <= '0;
            data_out_2     <= '0;
            data_out_debug <= '0;
        end else begin
            data_out_1     <= byp_1 ? write_data_in : rd_1;
            data_out_2     <= byp_2 ? write_data_in : rd_2;
            data_out_debug <= rd_dbg;
        end
    end

endmodule

// File: tb/tb_regfile_bypass.sv
// Directed bench for regfile_bypass: default build plus a
// 64-bit, 16-entry, non-bypassed build sharing one clock.
module tb_regfile_bypass;

    logic        clock;
    int          checks;
    int          failures;

    // default instance: DATA_W=32, ADDR_W=5, BYPASS=1
    logic        a_reset;
    logic        a_write;
    logic [4:0]  a_wa;
    logic [31:0] a_wd;
    logic [4:0]  a_ra1;
    logic [4:0]  a_ra2;
    logic [4:0]  a_rad;
    logic [31:0] a_d1;
    logic [31:0] a_d2;
    logic [31:0] a_dd;
    logic        a_busy;

    // variant instance: DATA_W=64, ADDR_W=4, BYPASS=0
    logic        b_reset;
    logic        b_write;
    logic [3:0]  b_wa;
    logic [63:0] b_wd;
    logic [3:0]  b_ra1;
    logic [3:0]  b_ra2;
    logic [3:0]  b_rad;
    logic [63:0] b_d1;
    logic [63:0] b_d2;
    logic [63:0] b_dd;
    logic        b_busy;

    regfile_bypass #(
        .DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)
    ) dut_a (
        .clock              (clock),
        .reset              (a_reset),
        .write              (a_write),
        .write_address      (a_wa),
        .write_data_in      (a_wd),
        .read_address_1     (a_ra1),
        .read_address_2     (a_ra2),
        .read_address_debug (a_rad),
        .data_out_1         (a_d1),
        .data_out_2         (a_d2),
        .data_out_debug     (a_dd),
        .busy               (a_busy)
    );

    regfile_bypass #(
        .DATA_W(64), .ADDR_W(4), .ZERO_REG(1), .BYPASS(0)
    ) dut_b (
        .clock              (clock),
        .reset              (b_reset),
        .write              (b_write),
        .write_address      (b_wa),
        .write_data_in      (b_wd),
        .read_address_1     (b_ra1),
        .read_address_2     (b_ra2),
        .read_address_debug (b_rad),
        .data_out_1         (b_d1),
        .data_out_2         (b_d2),
        .data_out_debug     (b_dd),
        .busy               (b_busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag,
                         input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // counts edges until busy drops; returns 999 if it never does
    task automatic count_a(output int n);
        n = 999;
        for (int i = 1; i <= 100; i++) begin
            tick();
            if (!a_busy) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic count_b(output int n);
        n = 999;
        for (int i = 1; i <= 100; i++) begin
            tick();
            if (!b_busy) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        int n;
        checks   = 0;
        failures = 0;
        a_reset = 1'b1; a_write = 1'b0; a_wa = '0; a_wd = '0;
        a_ra1 = '0; a_ra2 = '0; a_rad = '0;
        b_reset = 1'b1; b_write = 1'b0; b_wa = '0; b_wd = '0;
        b_ra1 = '0; b_ra2 = '0; b_rad = '0;

        // reset state
        tick();
        check("a_rst_busy", 64'(a_busy), 64'd1);
        check("a_rst_d1", 64'(a_d1), 64'd0);
        check("a_rst_d2", 64'(a_d2), 64'd0);
        check("a_rst_dd", 64'(a_dd), 64'd0);
        tick();
        check("a_rst_hold_busy", 64'(a_busy), 64'd1);

        // sweep with a write to x7 that must be lost
        a_reset = 1'b0;
        a_write = 1'b1; a_wa = 5'd7; a_wd = 32'hDEAD;
        count_a(n);
        a_write = 1'b0;
        check("a_sweep_len", 64'(n), 64'd32);

        // every entry reads zero after the sweep
        for (int i = 0; i < 32; i++) begin
            a_ra1 = 5'(i);
            a_ra2 = 5'(31 - i);
            a_rad = 5'(i);
            tick();
            check("a_clr_d1", 64'(a_d1), 64'd0);
            check("a_clr_d2", 64'(a_d2), 64'd0);
            check("a_clr_dd", 64'(a_dd), 64'd0);
        end
        a_ra1 = 5'd7;
        tick();
        check("a_x7_lost", 64'(a_d1), 64'd0);

        // basic write then registered read
        a_write = 1'b1; a_wa = 5'd5; a_wd = 32'h12345678;
        a_ra1 = 5'd0; a_ra2 = 5'd0;
        tick();
        a_write = 1'b0; a_ra1 = 5'd5;
        tick();
        check("a_rd_x5", 64'(a_d1), 64'h12345678);

        // both ports bypass on the same edge
        a_write = 1'b1; a_wa = 5'd5; a_wd = 32'hA5A5A5A5;
        a_ra1 = 5'd5; a_ra2 = 5'd5;
        tick();
        check("a_byp_d2", 64'(a_d2), 64'hA5A5A5A5);
        check("a_byp_d1", 64'(a_d1), 64'hA5A5A5A5);
        a_write = 1'b0;
        tick();
        check("a_x5_stored", 64'(a_d2), 64'hA5A5A5A5);

        // zero register
        a_write = 1'b1; a_wa = 5'd0; a_wd = 32'hFFFFFFFF;
        a_ra1 = 5'd0; a_rad = 5'd0;
        tick();
        check("a_x0_same", 64'(a_d1), 64'd0);
        a_write = 1'b0;
        tick();
        check("a_x0_next", 64'(a_d1), 64'd0);
        check("a_x0_dbg", 64'(a_dd), 64'd0);

        // debug port is never bypassed
        a_write = 1'b1; a_wa = 5'd3; a_wd = 32'h11;
        a_ra1 = 5'd3; a_rad = 5'd3;
        tick();
        check("a_dbg_byp_d1", 64'(a_d1), 64'h11);
        check("a_dbg_old", 64'(a_dd), 64'd0);
        a_write = 1'b0;
        tick();
        check("a_dbg_new", 64'(a_dd), 64'h11);

        // write x9, then reset again and interrupt the sweep
        a_write = 1'b1; a_wa = 5'd9; a_wd = 32'h99;
        tick();
        a_write = 1'b0; a_ra1 = 5'd9;
        tick();
        check("a_x9_set", 64'(a_d1), 64'h99);
        a_reset = 1'b1;
        tick();
        a_reset = 1'b0;
        repeat (10) tick();
        check("a_mid_busy", 64'(a_busy), 64'd1);
        a_reset = 1'b1;
        tick();
        check("a_mid_rst_busy", 64'(a_busy), 64'd1);
        check("a_mid_rst_d1", 64'(a_d1), 64'd0);
        a_reset = 1'b0;
        count_a(n);
        check("a_resweep_len", 64'(n), 64'd32);
        a_ra1 = 5'd9; a_ra2 = 5'd5; a_rad = 5'd3;
        tick();
        check("a_x9_cleared", 64'(a_d1), 64'd0);
        check("a_x5_cleared", 64'(a_d2), 64'd0);
        check("a_x3_cleared", 64'(a_dd), 64'd0);

        // variant: 16-entry sweep, no bypass, 64-bit data
        b_reset = 1'b0;
        count_b(n);
        check("b_sweep_len", 64'(n), 64'd16);
        b_write = 1'b1; b_wa = 4'd15;
        b_wd = 64'h0123456789ABCDEF;
        b_ra1 = 4'd15; b_ra2 = 4'd15;
        tick();
        check("b_nobyp_d1", b_d1, 64'd0);
        check("b_nobyp_d2", b_d2, 64'd0);
        b_write = 1'b0;
        tick();
        check("b_new_d1", b_d1, 64'h0123456789ABCDEF);
        check("b_new_d2", b_d2, 64'h0123456789ABCDEF);
        b_write = 1'b1; b_wa = 4'd0;
        b_wd = 64'hFFFFFFFFFFFFFFFF;
        b_ra1 = 4'd0; b_rad = 4'd0;
        tick();
        b_write = 1'b0;
        tick();
        check("b_x0_d1", b_d1, 64'd0);
        check("b_x0_dbg", b_dd, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_bypass.md
Name: regfile_bypass

Overview:
- Parametrised successor to the core's integer register file.
- Configurable data width and register count.
- Reads are registered on the same single clock, with write-to-read bypass and a hardwired zero register.
- A debug read port runs on the core clock; no second clock domain.
- Reset runs a sequential clear sweep that zeroes every entry and reports progress on `busy`.
- Sits in the decode stage and feeds the ID/EX pipeline register.

Parameters:
- DATA_W, 32, width of each register and of all data ports.
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries.
- ZERO_REG, 1, when 1 entry 0 always reads 0 and writes to it are discarded.
- BYPASS, 1, when 1 a same-edge write to a read address is forwarded to that read output.

Ports:
- clock  input  1  single clock, all logic on posedge.
- reset  input  1  synchronous, active-high.
- write  input  1  write enable.
- write_address  input  ADDR_W  write target.
- write_data_in  input  DATA_W  write data.
- read_address_1  input  ADDR_W  read port 1 address.
- read_address_2  input  ADDR_W  read port 2 address.
- read_address_debug  input  ADDR_W  debug read address.
- data_out_1  output  DATA_W  registered read port 1.
- data_out_2  output  DATA_W  registered read port 2.
- data_out_debug  output  DATA_W  registered debug read; never bypassed.
- busy  output  1  high while the clear sweep runs.

Behaviour:
- States are CLEAR and RUN, plus a clear index idx of width ADDR_W.
- Posedge with reset=1:
  - state<=CLEAR, idx<=0, busy<=1.
  - data_out_1, data_out_2 and data_out_debug <=0.
  - Array writes from the write port are ignored.
- Reset held for N cycles keeps idx=0.
- Reset asserted mid-sweep or in RUN restarts the sweep from idx 0.
- CLEAR, reset=0, each posedge:
  - mem[idx]<=0 and idx<=idx+1.
  - Outputs held at 0; write port ignored.
  - When idx==DEPTH-1: state<=RUN, busy<=0.
  - busy is therefore high for exactly DEPTH posedges after reset deasserts.
- RUN, each posedge:
  - If write=1 and not (ZERO_REG=1 and write_address==0): mem[write_address]<=write_data_in.
  - data_out_k <= mem[read_address_k], for k=1,2.
  - data_out_debug <= mem[read_address_debug].
- Read latency: 1 cycle. The address presented before edge E appears after edge E.
- Bypass (BYPASS=1): data_out_k takes write_data_in instead of the stored value when all hold at the edge:
  - write=1;
  - write_address==read_address_k;
  - not (ZERO_REG=1 and address 0).
- Both read ports may bypass on the same edge.
- Debug port sees the pre-write value on the write edge and the new value one cycle later.
- BYPASS=0: a read on the write edge returns the old value; the new value is visible from the next edge.
- ZERO_REG=1: any read of address 0 returns 0, even right after a write to address 0.
- Out-of-range addresses cannot occur because DEPTH=2**ADDR_W.
- Width: no truncation or extension. All data paths are exactly DATA_W.

Test Plan:
- Clear sweep: pulse reset 1 cycle, ADDR_W=5 -> busy high exactly 32 posedges, then low. Reads of all 32 addresses then return 0. A write to x7=0xDEAD during the sweep is lost (x7 reads 0).
- Basic write/read: write x5=0x12345678, next cycle read_address_1=5 -> data_out_1=0x12345678 one edge later. Write x5=0xA5A5A5A5 with read_address_2=5 on the same edge -> data_out_2=0xA5A5A5A5 on that edge (bypass).
- Zero register: write x0=0xFFFFFFFF with read_address_1=0 on the same edge and the next edge -> data_out_1=0 both times. Debug read of x0 -> 0.
- Debug vs. bypass: write x3=0x11 with read_address_debug=3 and read_address_1=3 on the same edge -> data_out_1=0x11, data_out_debug=old value (0). Next edge -> data_out_debug=0x11.
- Reset mid-sweep: assert reset at sweep cycle 10 -> busy stays high. After release, a full 32 more cycles pass before busy=0. Prior contents (e.g. x9=0x99 written before the first reset) read 0.
- Parameter variant: DATA_W=64, ADDR_W=4, BYPASS=0 -> sweep 16 cycles. Write x15=0x0123456789ABCDEF while reading x15 -> old value 0, then the new value next edge.
